// File: rtl/router_ctrl.sv
// Tile sequencer for the multi-row activation router: clear, program AGs, stream SRAM, drain MISO.
// Optional cycle counters are enabled by defining ROUTER_CTRL_PERF_EN.
module router_ctrl #(
    parameter int unsigned ROUTER_COUNT = 4,
    parameter int unsigned ADDR_WIDTH   = 8
) (
    input  logic                    i_clk,
    input  logic                    i_nrst,
    input  logic                    i_start,
    input  logic [ADDR_WIDTH-1:0]   i_o_x,
    input  logic [ADDR_WIDTH-1:0]   i_o_y,
    input  logic [ADDR_WIDTH-1:0]   i_i_size,
    input  logic [ADDR_WIDTH-1:0]   i_start_addr,
    input  logic [ADDR_WIDTH-1:0]   i_fetch_base,
    input  logic [ADDR_WIDTH-1:0]   i_fetch_count,
    input  logic                    i_addr_empty,
    input  logic                    i_data_empty,
    output logic                    o_reg_clear,
    output logic                    o_ag_en,
    output logic [ROUTER_COUNT-1:0] o_row_id,
    output logic [ADDR_WIDTH-1:0]   o_o_x,
    output logic [ADDR_WIDTH-1:0]   o_o_y,
    output logic [ADDR_WIDTH-1:0]   o_i_size,
    output logic [ADDR_WIDTH-1:0]   o_start_addr,
    output logic                    o_sram_rd_en,
    output logic [ADDR_WIDTH-1:0]   o_sram_addr,
    output logic                    o_ac_en,
    output logic [ADDR_WIDTH-1:0]   o_rr_addr,
    output logic                    o_rr_data_valid,
    output logic                    o_miso_pop_en,
    output logic                    o_busy,
    output logic                    o_done
`ifdef ROUTER_CTRL_PERF_EN
    ,
    output logic [ADDR_WIDTH-1:0]   o_cyc_fetch,
    output logic [ADDR_WIDTH-1:0]   o_cyc_stall
`endif
);

    localparam int unsigned W = ADDR_WIDTH;
    localparam logic [W-1:0] LAST_ROW = W'(ROUTER_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, GEN, FETCH, FLUSH, WAIT_AG, DRAIN, DONE
    } state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   cnt, cnt_nxt;

    logic [W-1:0]   cfg_o_x, cfg_o_y, cfg_i_size, cfg_start_addr, cfg_fetch_base, cfg_fetch_count;

    logic                    reg_clear_nxt, ag_en_nxt, rd_en_nxt, ac_en_nxt, pop_en_nxt, done_nxt;
    logic [ROUTER_COUNT-1:0] row_id_nxt;
    logic [W-1:0]            o_x_nxt, o_y_nxt, i_size_nxt, start_addr_nxt, sram_addr_nxt;

    // Tile parameters are captured once at acceptance
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            cfg_o_x         <= '0;
            cfg_o_y         <= '0;
            cfg_i_size      <= '0;
            cfg_start_addr  <= '0;
            cfg_fetch_base  <= '0;
            cfg_fetch_count <= '0;
        end else if (state == IDLE && i_start) begin
            cfg_o_x         <= i_o_x;
            cfg_o_y         <= i_o_y;
            cfg_i_size      <= i_i_size;
            cfg_start_addr  <= i_start_addr;
            cfg_fetch_base  <= i_fetch_base;
            cfg_fetch_count <= i_fetch_count;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt is the row index in GEN, the read index in FETCH and the cycle index in DRAIN
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                state_nxt = GEN;
                cnt_nxt   = '0;
            end
            GEN: begin
                if (cnt == LAST_ROW) begin
                    cnt_nxt   = '0;
                    state_nxt = (cfg_fetch_count == '0) ? DRAIN : FETCH;
                end else begin
                    cnt_nxt = cnt + W'(1);
                end
            end
            FETCH: begin
                if (cnt == cfg_fetch_count - W'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = FLUSH;
                end else begin
                    cnt_nxt = cnt + W'(1);
                end
            end
            FLUSH:   state_nxt = WAIT_AG;
            WAIT_AG: begin
                if (i_addr_empty) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (i_data_empty) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else if (cnt != '1) begin
                    cnt_nxt = cnt + W'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so the registers line up with it
    always_comb begin
        reg_clear_nxt  = 1'b0;
        ag_en_nxt      = 1'b0;
        row_id_nxt     = '0;
        o_x_nxt        = '0;
        o_y_nxt        = '0;
        i_size_nxt     = '0;
        start_addr_nxt = '0;
        rd_en_nxt      = 1'b0;
        sram_addr_nxt  = '0;
        ac_en_nxt      = 1'b0;
        pop_en_nxt     = 1'b0;
        done_nxt       = 1'b0;
        case (state_nxt)
            CLEAR: reg_clear_nxt = 1'b1;
            GEN: begin
                ag_en_nxt      = 1'b1;
                row_id_nxt     = ROUTER_COUNT'(cnt_nxt);
                o_x_nxt        = cfg_o_x + cnt_nxt;
                o_y_nxt        = cfg_o_y;
                i_size_nxt     = cfg_i_size;
                start_addr_nxt = cfg_start_addr;
            end
            FETCH: begin
                rd_en_nxt     = 1'b1;
                sram_addr_nxt = cfg_fetch_base + cnt_nxt;
                ac_en_nxt     = 1'b1;
            end
            FLUSH, WAIT_AG: ac_en_nxt = 1'b1;
            DRAIN:          pop_en_nxt = 1'b1;
            DONE:           done_nxt = 1'b1;
            default: ;
        endcase
    end

    // Router address/valid trail the SRAM request by its one-cycle read latency
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_reg_clear     <= 1'b0;
            o_ag_en         <= 1'b0;
            o_row_id        <= '0;
            o_o_x           <= '0;
            o_o_y           <= '0;
            o_i_size        <= '0;
            o_start_addr    <= '0;
            o_sram_rd_en    <= 1'b0;
            o_sram_addr     <= '0;
            o_ac_en         <= 1'b0;
            o_rr_addr       <= '0;
            o_rr_data_valid <= 1'b0;
            o_miso_pop_en   <= 1'b0;
            o_done          <= 1'b0;
        end else begin
            o_reg_clear     <= reg_clear_nxt;
            o_ag_en         <= ag_en_nxt;
            o_row_id        <= row_id_nxt;
            o_o_x           <= o_x_nxt;
            o_o_y           <= o_y_nxt;
            o_i_size        <= i_size_nxt;
            o_start_addr    <= start_addr_nxt;
            o_sram_rd_en    <= rd_en_nxt;
            o_sram_addr     <= sram_addr_nxt;
            o_ac_en         <= ac_en_nxt;
            o_rr_addr       <= o_sram_addr;
            o_rr_data_valid <= o_sram_rd_en;
            o_miso_pop_en   <= pop_en_nxt;
            o_done          <= done_nxt;
        end
    end

    assign o_busy = (state != IDLE);

`ifdef ROUTER_CTRL_PERF_EN
    // Saturating per-tile counters; drain only stalls once it outlasts one pop per router
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_cyc_fetch <= '0;
            o_cyc_stall <= '0;
        end else if (state_nxt == CLEAR) begin
            o_cyc_fetch <= '0;
            o_cyc_stall <= '0;
        end else begin
            if ((state_nxt == FETCH || state_nxt == FLUSH || state_nxt == WAIT_AG)
                && o_cyc_fetch != '1)
                o_cyc_fetch <= o_cyc_fetch + W'(1);
            if ((state_nxt == WAIT_AG || (state_nxt == DRAIN && cnt_nxt >= W'(ROUTER_COUNT)))
                && o_cyc_stall != '1)
                o_cyc_stall <= o_cyc_stall + W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_router_ctrl.sv
// Directed table-driven bench for router_ctrl (default ROUTER_COUNT=4, ADDR_WIDTH=8).
module tb_router_ctrl;

    logic       clk = 1'b0;
    logic       nrst;
    logic       start;
    logic [7:0] o_x, o_y, i_size, start_addr, fetch_base, fetch_count;
    logic       addr_empty, data_empty;
    logic       reg_clear, ag_en;
    logic [3:0] row_id;
    logic [7:0] ag_o_x, ag_o_y, ag_i_size, ag_start_addr;
    logic       sram_rd_en;
    logic [7:0] sram_addr;
    logic       ac_en;
    logic [7:0] rr_addr;
    logic       rr_data_valid, miso_pop_en, busy, done;
`ifdef ROUTER_CTRL_PERF_EN
    logic [7:0] cyc_fetch, cyc_stall;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    router_ctrl #(.ROUTER_COUNT(4), .ADDR_WIDTH(8)) dut (
        .i_clk(clk), .i_nrst(nrst), .i_start(start),
        .i_o_x(o_x), .i_o_y(o_y), .i_i_size(i_size), .i_start_addr(start_addr),
        .i_fetch_base(fetch_base), .i_fetch_count(fetch_count),
        .i_addr_empty(addr_empty), .i_data_empty(data_empty),
        .o_reg_clear(reg_clear), .o_ag_en(ag_en), .o_row_id(row_id),
        .o_o_x(ag_o_x), .o_o_y(ag_o_y), .o_i_size(ag_i_size), .o_start_addr(ag_start_addr),
        .o_sram_rd_en(sram_rd_en), .o_sram_addr(sram_addr), .o_ac_en(ac_en),
        .o_rr_addr(rr_addr), .o_rr_data_valid(rr_data_valid), .o_miso_pop_en(miso_pop_en),
        .o_busy(busy), .o_done(done)
`ifdef ROUTER_CTRL_PERF_EN
        , .o_cyc_fetch(cyc_fetch), .o_cyc_stall(cyc_stall)
`endif
    );

    logic any_out;
    assign any_out = |{reg_clear, ag_en, row_id, ag_o_x, ag_o_y, ag_i_size, ag_start_addr,
                       sram_rd_en, sram_addr, ac_en, rr_addr, rr_data_valid, miso_pop_en,
                       busy, done};

    typedef struct {
        logic [7:0]       ox, oy, isz, sa, base, cnt;
        int               ae_rel, de_rel, glitch_t;
        bit               start_in_done;
        logic [3:0][7:0]  exp_ox;
        logic [7:0]       exp_a0, exp_alast;
        int               exp_ac, exp_pop, exp_lat, exp_stall, exp_fetch;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int wrap8(input int x);
        return x & 255;
    endfunction

    // Runs one tile starting at the current negedge; ends at the negedge after DONE
    task automatic run_tile(input vec_t v);
        int t = 0, done_t = 0, clr_cnt = 0, clr_t = 0, ag_cnt = 0, ag_t = 0;
        int rd_cnt = 0, rd_t = 0, rr_cnt = 0, rr_t = 0, ac_cnt = 0, pop_cnt = 0, last_pop_t = 0;
        o_x = v.ox; o_y = v.oy; i_size = v.isz; start_addr = v.sa;
        fetch_base = v.base; fetch_count = v.cnt;
        addr_empty = (v.ae_rel == 0);
        data_empty = (v.de_rel == 0);
        start = 1'b1;
        while (done_t == 0 && t < 200) begin
            @(negedge clk);
            t++;
            if (t == 1) begin
                o_x = 8'h5A; o_y = 8'hA5; i_size = 8'h33; start_addr = 8'hCC;
                fetch_base = 8'h99; fetch_count = 8'h77;
            end
            if (t == 1 || (v.glitch_t != 0 && t == v.glitch_t + 1)) start = 1'b0;
            if (v.glitch_t != 0 && t == v.glitch_t) start = 1'b1;
            if (reg_clear) begin
                clr_cnt++;
                if (clr_t == 0) clr_t = t;
            end
            if (ag_en) begin
                if (ag_t == 0) ag_t = t;
                check("ag_row_id", int'(row_id), ag_cnt);
                if (ag_cnt < 4) check("ag_o_x", int'(ag_o_x), int'(v.exp_ox[ag_cnt]));
                check("ag_o_y", int'(ag_o_y), int'(v.oy));
                check("ag_i_size", int'(ag_i_size), int'(v.isz));
                check("ag_start_addr", int'(ag_start_addr), int'(v.sa));
                ag_cnt++;
            end
            if (sram_rd_en) begin
                if (rd_t == 0) rd_t = t;
                check("sram_addr", int'(sram_addr), wrap8(int'(v.base) + rd_cnt));
                if (rd_cnt == 0) check("sram_addr_first", int'(sram_addr), int'(v.exp_a0));
                if (rd_cnt == int'(v.cnt) - 1)
                    check("sram_addr_last", int'(sram_addr), int'(v.exp_alast));
                rd_cnt++;
            end
            if (rr_data_valid) begin
                if (rr_t == 0) rr_t = t;
                check("rr_addr", int'(rr_addr), wrap8(int'(v.base) + rr_cnt));
                rr_cnt++;
            end
            if (ac_en) ac_cnt++;
            if (v.ae_rel != 0 && ac_cnt == v.ae_rel) addr_empty = 1'b1;
            if (miso_pop_en) begin
                pop_cnt++;
                last_pop_t = t;
            end
            if (v.de_rel != 0 && pop_cnt == v.de_rel) data_empty = 1'b1;
            if (done) done_t = t;
        end
        check("clear_pulses", clr_cnt, 1);
        check("clear_cycle", clr_t, 1);
        check("ag_cycles", ag_cnt, 4);
        check("ag_first_cycle", ag_t, 2);
        check("rd_count", rd_cnt, int'(v.cnt));
        check("rr_count", rr_cnt, int'(v.cnt));
        if (v.cnt != 0) begin
            check("rd_first_cycle", rd_t, 6);
            check("rr_first_cycle", rr_t, 7);
        end
        check("ac_en_cycles", ac_cnt, v.exp_ac);
        check("pop_en_cycles", pop_cnt, v.exp_pop);
        check("done_latency", done_t, v.exp_lat);
        check("done_after_drain", done_t, last_pop_t + 1);
        if (v.start_in_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("idle_after_done", int'(busy), 0);
        check("no_restart_clear", int'(reg_clear), 0);
        check("done_one_cycle", int'(done), 0);
`ifdef ROUTER_CTRL_PERF_EN
        check("cyc_fetch", int'(cyc_fetch), v.exp_fetch);
        check("cyc_stall", int'(cyc_stall), v.exp_stall);
`endif
    endtask

    initial begin
        int found;
        int bad;
        nrst = 1'b0; start = 1'b0;
        o_x = '0; o_y = '0; i_size = '0; start_addr = '0; fetch_base = '0; fetch_count = '0;
        addr_empty = 1'b1; data_empty = 1'b1;

        //            ox     oy     isz    sa     base   cnt    ae  de  gl sid exp_ox                                 a0     alast  ac  pop lat stall fetch
        vecs[0] = '{8'h02, 8'h05, 8'h10, 8'h20, 8'h10, 8'd3, 0,  0,  0, 0, {8'h05, 8'h04, 8'h03, 8'h02}, 8'h10, 8'h12, 5,  1,  12, 1,  5};
        vecs[1] = '{8'hFE, 8'h07, 8'h08, 8'h00, 8'hFF, 8'd2, 0,  0,  0, 0, {8'h01, 8'h00, 8'hFF, 8'hFE}, 8'hFF, 8'h00, 4,  1,  11, 1,  4};
        vecs[2] = '{8'h09, 8'h01, 8'h04, 8'h03, 8'h30, 8'd0, 0,  0,  0, 0, {8'h0C, 8'h0B, 8'h0A, 8'h09}, 8'h00, 8'h00, 0,  1,  7,  0,  0};
        vecs[3] = '{8'h00, 8'h02, 8'h20, 8'h80, 8'h50, 8'd8, 15, 8,  0, 0, {8'h03, 8'h02, 8'h01, 8'h00}, 8'h50, 8'h57, 15, 8,  29, 10, 15};
        vecs[4] = '{8'h10, 8'h03, 8'h14, 8'h04, 8'h00, 8'd1, 0,  0,  3, 1, {8'h13, 8'h12, 8'h11, 8'h10}, 8'h00, 8'h00, 3,  1,  10, 1,  3};

        repeat (3) @(negedge clk);
        check("reset_outputs", int'(any_out), 0);
        nrst = 1'b1;
        @(negedge clk);
        check("idle_after_reset", int'(busy), 0);

        // Reset while FETCH is issuing its fourth read
        o_x = 8'h01; o_y = 8'h02; i_size = 8'h08; start_addr = 8'h00;
        fetch_base = 8'h40; fetch_count = 8'd8;
        start = 1'b1;
        found = 0;
        for (int t = 1; t <= 40 && found == 0; t++) begin
            @(negedge clk);
            if (t == 1) start = 1'b0;
            if (sram_rd_en && sram_addr == 8'h43) found = 1;
        end
        check("rst_reached_k3", found, 1);
        nrst = 1'b0;
        #1;
        check("rst_outputs_zero", int'(any_out), 0);
        check("rst_busy_low", int'(busy), 0);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) bad++;
        end
        nrst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        check("rst_no_done_stays_idle", bad, 0);

        for (int i = 0; i < 5; i++) run_tile(vecs[i]);

        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy || reg_clear) bad++;
        end
        check("done_cycle_start_ignored", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/router_ctrl.md
Name: router_ctrl

Overview:
- Sequencer for the multi-row activation router (ROUTER_COUNT row routers).
- Per tile it runs four phases in order: clear router registers, program one address generator per row, stream SRAM words through the address comparators, then drain the MISO outputs toward the PE array.
- Sits between the layer-level scheduler (start/done handshake) and the router plus its activation SRAM.

Parameters:
- ROUTER_COUNT, 4, number of row routers and output pixels per tile.
- ADDR_WIDTH, 8, width of SRAM addresses, coordinates and sizes.

Ports:
- i_clk  in  1  clock
- i_nrst  in  1  async active-low reset
- i_start  in  1  one-cycle tile start pulse; ignored unless IDLE
- i_o_x  in  ADDR_WIDTH  x of first output pixel of the tile
- i_o_y  in  ADDR_WIDTH  y of the tile's output row
- i_i_size  in  ADDR_WIDTH  input feature-map width
- i_start_addr  in  ADDR_WIDTH  feature-map base address
- i_fetch_base  in  ADDR_WIDTH  first SRAM word to read
- i_fetch_count  in  ADDR_WIDTH  number of SRAM words to read
- i_addr_empty  in  1  router o_addr_empty
- i_data_empty  in  1  router o_data_empty
- o_reg_clear  out  1  router i_reg_clear
- o_ag_en  out  1  router i_ag_en
- o_row_id  out  ROUTER_COUNT  router i_row_id (binary row index)
- o_o_x, o_o_y, o_i_size, o_start_addr  out  ADDR_WIDTH each  router AG inputs
- o_sram_rd_en  out  1  SRAM read enable
- o_sram_addr  out  ADDR_WIDTH  SRAM read address
- o_ac_en  out  1  router i_ac_en
- o_rr_addr  out  ADDR_WIDTH  router i_addr, aligned with SRAM data
- o_rr_data_valid  out  1  router i_data_valid
- o_miso_pop_en  out  1  router i_miso_pop_en
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse at tile completion

Behaviour:
- Reset (i_nrst low, async): state IDLE, all outputs 0, all counters 0. Reset mid-operation aborts the tile with no done pulse.
- On i_start in IDLE: register i_o_x, i_o_y, i_i_size, i_start_addr, i_fetch_base, i_fetch_count. Later input changes do not affect the tile.
- CLEAR, 1 cycle:
  - o_reg_clear=1.
  - Next state: GEN.
- GEN, ROUTER_COUNT cycles, r = 0..ROUTER_COUNT-1:
  - o_ag_en=1, o_row_id=r.
  - o_o_x = reg_o_x + r, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH).
  - o_o_y, o_i_size, o_start_addr come from the registered values.
  - After r = ROUTER_COUNT-1: next state FETCH, or DRAIN if count==0.
- FETCH:
  - Issue one read per cycle: o_sram_rd_en=1, o_sram_addr = base+k for k = 0..count-1, wrapping.
  - SRAM latency is 1 cycle. o_rr_addr and o_rr_data_valid are the issued address and rd_en delayed by one register stage.
  - o_ac_en=1 throughout FETCH and for one extra cycle after the last issue (so the last valid word is compared). Then go to WAIT_AG.
- WAIT_AG:
  - o_ac_en=1 until i_addr_empty is sampled 1, then go to DRAIN.
  - If i_addr_empty is already 1 on entry, this takes 1 cycle.
- DRAIN:
  - o_miso_pop_en=1 until i_data_empty is sampled 1. o_miso_pop_en is deasserted in the cycle that sampling occurs.
  - Next state: DONE.
- DONE, 1 cycle:
  - o_done=1, o_busy=0 in the next cycle.
  - Next state: IDLE.
- i_start while busy: ignored, with no queueing.
- i_start in the DONE cycle: ignored. A new tile may start from the cycle after DONE.
- All outputs are registered, except o_busy, which is decoded from state.
- Latency with count=N and all empties ready on entry: 1 (CLEAR) + ROUTER_COUNT + N + 1 + 1 + 1 + 1 cycles from the start acceptance edge to the o_done pulse.

Optional Feature:
- Macro: ROUTER_CTRL_PERF_EN.
- Defined:
  - Adds outputs o_cyc_fetch and o_cyc_stall (ADDR_WIDTH each, saturating).
  - o_cyc_fetch counts FETCH+WAIT_AG cycles of the current tile.
  - o_cyc_stall counts WAIT_AG cycles plus DRAIN cycles beyond ROUTER_COUNT.
  - Both are cleared in CLEAR and held after DONE until the next CLEAR.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-FETCH (N=8, nrst low at k=3) -> all outputs 0 immediately, state IDLE, no o_done. A new start then behaves normally.
- Basic tile: ROUTER_COUNT=4, o_x=2, o_y=5, base=0x10, count=3, empties tied 1 ->
  - clear pulse 1 cycle;
  - ag_en 4 cycles with row_id 0,1,2,3 and o_x 2,3,4,5;
  - sram_addr 0x10,0x11,0x12;
  - rr_data_valid one cycle later with rr_addr 0x10..0x12;
  - o_done exactly 12 cycles after start.
- Wrap: o_x=0xFE gives o_o_x 0xFE,0xFF,0x00,0x01; base=0xFF, count=2 gives sram_addr 0xFF,0x00.
- count=0 -> FETCH skipped, no rd_en, DRAIN entered right after GEN, done pulses.
- Backpressure: i_addr_empty held 0 for 5 cycles after fetch, then i_data_empty held 0 for 7 DRAIN cycles -> ac_en and miso_pop_en stay asserted accordingly, done 1 cycle after data_empty=1. With PERF_EN: o_cyc_stall = 5 + 1 + (8 - 4).
- i_start pulsed during GEN and in the DONE cycle -> ignored, no second tile. A start one cycle after DONE is accepted.
